// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive-sweep checker.
// Contents:
//   - sweep_state_t : controller states (IDLE, RUN, DONE)
//   - settle_width  : width of the settle counter for a given SETTLE value
//   - SETTLE_W      : settle counter width for the default SETTLE of 1
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  // Bits needed to count 0..settle inclusive, never less than one bit.
  // Written as a loop so it stays a plain constant function for any tool.
  function automatic int settle_width(input int settle);
    int w;
    w = 1;
    while ((1 << w) <= settle) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int SETTLE_DEFAULT = 1;
  localparam int SETTLE_W       = settle_width(SETTLE_DEFAULT);

endpackage

// File: rtl/sweep_vec_ctr.sv
// Vector and settle counters for the exhaustive-sweep checker.
// o_stim is the vector currently applied to the DUT and the reference model.
// o_cmp is high on the cycle whose closing edge samples the outputs, i.e.
// once the vector has been held for SETTLE idle cycles.
// o_last flags the all-ones vector, the final one of the sweep.
// i_clear returns both counters to zero and wins over i_en.
module sweep_vec_ctr
  import sweep_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_en,
  output logic [IN_W-1:0] o_stim,
  output logic            o_cmp,
  output logic            o_last
);

  localparam int                 SW        = settle_width(SETTLE);
  localparam logic [SW-1:0]      SETTLE_V  = SW'(SETTLE);
  localparam logic [SW-1:0]      SETTLE_1  = SW'(1);
  localparam logic [IN_W-1:0]    STIM_ONE  = IN_W'(1);
  localparam logic [IN_W-1:0]    STIM_LAST = {IN_W{1'b1}};

  logic [IN_W-1:0] stim_q;
  logic [IN_W-1:0] stim_d;
  logic [SW-1:0]   settle_q;
  logic [SW-1:0]   settle_d;

  // Compare strobe and last-vector flag are decoded straight from the counters.
  always_comb begin
    o_stim = stim_q;
    o_cmp  = i_en && (settle_q == SETTLE_V);
    o_last = (stim_q == STIM_LAST);
  end

  // Hold each vector for SETTLE cycles, then advance and restart the settle count.
  always_comb begin
    stim_d   = stim_q;
    settle_d = settle_q;
    if (i_clear) begin
      stim_d   = '0;
      settle_d = '0;
    end else if (i_en) begin
      if (o_cmp) begin
        stim_d   = stim_q + STIM_ONE;
        settle_d = '0;
      end else begin
        settle_d = settle_q + SETTLE_1;
      end
    end
  end

  // Counter registers, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stim_q   <= '0;
      settle_q <= '0;
    end else begin
      stim_q   <= stim_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/vec_sweep_checker.sv
// Exhaustive-stimulus checker for small combinational blocks.
// Walks o_stim through every value 0 .. 2^IN_W-1, waits SETTLE cycles per
// vector, compares the DUT output with the reference-model output and keeps
// a saturating mismatch count plus the lowest failing vector.
// Build option:
//   SWEEP_STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep
//                           on its compare edge; otherwise every vector is
//                           applied and every mismatch is counted.
module vec_sweep_checker
  import sweep_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [OUT_W-1:0] i_dut_y,
  input  logic [OUT_W-1:0] i_exp_y,
  output logic [IN_W-1:0]  o_stim,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [IN_W:0]    o_err_cnt,
  output logic             o_first_fail_valid,
  output logic [IN_W-1:0]  o_first_fail_vec
);

  // All vectors failing gives exactly 2^IN_W, which is also the saturation point.
  localparam logic [IN_W:0] ERR_MAX = {1'b1, {IN_W{1'b0}}};
  localparam logic [IN_W:0] ERR_ONE = (IN_W + 1)'(1);

  sweep_state_t    state_q;
  sweep_state_t    state_d;
  logic [IN_W:0]   err_cnt_q;
  logic [IN_W:0]   err_cnt_d;
  logic            ff_valid_q;
  logic            ff_valid_d;
  logic [IN_W-1:0] ff_vec_q;
  logic [IN_W-1:0] ff_vec_d;
  logic            pass_q;
  logic            pass_d;

  logic            ctr_clear;
  logic            ctr_en;
  logic [IN_W-1:0] vec;
  logic            vec_cmp;
  logic            vec_last;
  logic            mismatch;
  logic            sweep_end;

  sweep_vec_ctr #(
    .IN_W   (IN_W),
    .SETTLE (SETTLE)
  ) u_vec_ctr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (ctr_clear),
    .i_en    (ctr_en),
    .o_stim  (vec),
    .o_cmp   (vec_cmp),
    .o_last  (vec_last)
  );

  // Case-equality so that X/Z on either side shows up as a mismatch in simulation.
  always_comb begin
    mismatch = (i_dut_y !== i_exp_y);
  end

  // Decide whether the current compare edge is the last one of the sweep.
`ifdef SWEEP_STOP_ON_FAIL_EN
  always_comb begin
    sweep_end = vec_last || mismatch;
  end
`else
  always_comb begin
    sweep_end = vec_last;
  end
`endif

  // Controller: start/restart, per-vector result accumulation and sweep completion.
  always_comb begin
    state_d    = state_q;
    err_cnt_d  = err_cnt_q;
    ff_valid_d = ff_valid_q;
    ff_vec_d   = ff_vec_q;
    pass_d     = pass_q;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d    = RUN;
          err_cnt_d  = '0;
          ff_valid_d = 1'b0;
          ff_vec_d   = '0;
          pass_d     = 1'b0;
          ctr_clear  = 1'b1;
        end
      end
      RUN: begin
        ctr_en = 1'b1;
        if (vec_cmp) begin
          if (mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_ONE;
            end
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_vec_d   = vec;
            end
          end
          if (sweep_end) begin
            state_d   = DONE;
            pass_d    = (err_cnt_d == '0);
            ctr_clear = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      err_cnt_q  <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      ff_valid_q <= ff_valid_d;
      ff_vec_q   <= ff_vec_d;
      pass_q     <= pass_d;
    end
  end

  // Status outputs decoded from the registered state and results.
  always_comb begin
    o_stim             = vec;
    o_busy             = (state_q == RUN);
    o_done             = (state_q == DONE);
    o_pass             = pass_q;
    o_err_cnt          = err_cnt_q;
    o_first_fail_valid = ff_valid_q;
    o_first_fail_vec   = ff_vec_q;
  end

endmodule

// File: tb/tb_vec_sweep_checker.sv
// Self-checking bench for vec_sweep_checker.
// Main instance: default parameters driving a 3-to-8 decoder whose output is
// corrupted by a per-vector fault mask; golden model is a clean decoder.
// Second instance: IN_W=1, OUT_W=1, SETTLE=0 with an AND-gate DUT.
// Expected results come from a sweep-level model over the fault masks.
module tb_vec_sweep_checker;

  localparam int IN_W        = 3;
  localparam int OUT_W       = 8;
  localparam int SETTLE      = 1;
  localparam int NVEC        = 1 << IN_W;
  localparam int CPV         = SETTLE + 1;
  localparam int CYCLE_LIMIT = 200;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [OUT_W-1:0] dut_y;
  logic [OUT_W-1:0] exp_y;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [IN_W:0]    err_cnt;
  logic             ffv;
  logic [IN_W-1:0]  ffvec;
  logic [OUT_W-1:0] fault_mask [NVEC];

  logic             s_start;
  logic             s_dut_y;
  logic             s_exp_y;
  logic [0:0]       s_stim;
  logic             s_busy;
  logic             s_done;
  logic             s_pass;
  logic [1:0]       s_err;
  logic             s_ffv;
  logic [0:0]       s_ffvec;
  logic             s_fault [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Decoder DUT with injectable faults, and its golden model
  always_comb begin
    exp_y = 8'd1 << stim;
    dut_y = exp_y ^ fault_mask[stim];
  end

  // AND-gate DUT (second input tied high) against a wire model
  always_comb begin
    s_exp_y = s_stim[0];
    s_dut_y = (s_stim[0] & 1'b1) ^ s_fault[s_stim[0]];
  end

  vec_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) u_dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_dut_y            (dut_y),
    .i_exp_y            (exp_y),
    .o_stim             (stim),
    .o_busy             (busy),
    .o_done             (done),
    .o_pass             (pass),
    .o_err_cnt          (err_cnt),
    .o_first_fail_valid (ffv),
    .o_first_fail_vec   (ffvec)
  );

  vec_sweep_checker #(.IN_W(1), .OUT_W(1), .SETTLE(0)) u_small (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (s_start),
    .i_dut_y            (s_dut_y),
    .i_exp_y            (s_exp_y),
    .o_stim             (s_stim),
    .o_busy             (s_busy),
    .o_done             (s_done),
    .o_pass             (s_pass),
    .o_err_cnt          (s_err),
    .o_first_fail_valid (s_ffv),
    .o_first_fail_vec   (s_ffvec)
  );

  // Sweep-level model: which vectors fail, how many, and when the sweep ends
  task automatic model_sweep(output int cnt, output int first, output int cycles);
    cnt    = 0;
    first  = -1;
    cycles = NVEC * CPV;
    for (int v = 0; v < NVEC; v++) begin
      if (fault_mask[v] != '0) begin
        cnt++;
        if (first < 0) first = v;
        if (STOP_ON_FAIL) begin
          cycles = (v + 1) * CPV;
          break;
        end
      end
    end
  endtask

  // Pulse start, then follow the sweep until busy drops (bounded)
  task automatic run_sweep(input int repulse_at, output int cycles, output int stim_errs,
                           output int err_at_start, output logic done_at_start);
    cycles    = 0;
    stim_errs = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    err_at_start  = int'(err_cnt);
    done_at_start = done;
    while (busy === 1'b1 && cycles < CYCLE_LIMIT) begin
      if (int'(stim) != cycles / CPV) stim_errs++;
      start = (cycles == repulse_at);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, pass, err_cnt, ffv, ffvec, stim} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_main: outputs got %b want all zero", {busy, done, pass, err_cnt, ffv, ffvec, stim});
    end
    n_checks++;
    if ({s_busy, s_done, s_pass, s_err, s_ffv, s_ffvec, s_stim} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_small: outputs got %b want all zero", {s_busy, s_done, s_pass, s_err, s_ffv, s_ffvec, s_stim});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, pass, err_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: outputs got %b want all zero", {busy, done, pass, err_cnt});
    end
  endtask

  task automatic test_fault_patterns();
    logic [OUT_W-1:0] pat [4][NVEC];
    string name [4];
    int cnt, first, exp_cyc, cycles, stim_errs, e0;
    logic d0;
    name[0] = "all_pass";
    name[1] = "bit0_at_5";
    name[2] = "all_inverted";
    name[3] = "faults_2_6";
    for (int v = 0; v < NVEC; v++) begin
      pat[0][v] = 8'h00;
      pat[1][v] = (v == 5) ? 8'h01 : 8'h00;
      pat[2][v] = 8'hFF;
      pat[3][v] = (v == 2 || v == 6) ? 8'h10 : 8'h00;
    end
    for (int p = 0; p < 4; p++) begin
      for (int v = 0; v < NVEC; v++) fault_mask[v] = pat[p][v];
      model_sweep(cnt, first, exp_cyc);
      run_sweep(-1, cycles, stim_errs, e0, d0);
      n_checks++;
      if (cycles != exp_cyc) begin
        n_fail++;
        $display("[TB] FAIL %s done_latency: got %0d cycles want %0d", name[p], cycles, exp_cyc);
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s done_busy: got done=%b busy=%b want done=1 busy=0", name[p], done, busy);
      end
      n_checks++;
      if (int'(err_cnt) != cnt) begin
        n_fail++;
        $display("[TB] FAIL %s err_cnt: got %0d want %0d", name[p], err_cnt, cnt);
      end
      n_checks++;
      if (pass !== (cnt == 0)) begin
        n_fail++;
        $display("[TB] FAIL %s pass: got %b want %b", name[p], pass, (cnt == 0));
      end
      n_checks++;
      if (ffv !== (cnt > 0) || int'(ffvec) != ((first < 0) ? 0 : first)) begin
        n_fail++;
        $display("[TB] FAIL %s first_fail: got valid=%b vec=%0d want valid=%b vec=%0d",
                 name[p], ffv, ffvec, (cnt > 0), (first < 0) ? 0 : first);
      end
      n_checks++;
      if (stim_errs != 0 || stim !== '0) begin
        n_fail++;
        $display("[TB] FAIL %s stim_sequence: got %0d step errors, final stim %0d want 0 and 0",
                 name[p], stim_errs, stim);
      end
    end
  endtask

  task automatic test_random_faults();
    int cnt, first, exp_cyc, cycles, stim_errs, e0;
    logic d0;
    for (int it = 0; it < 8; it++) begin
      for (int v = 0; v < NVEC; v++) begin
        fault_mask[v] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      end
      model_sweep(cnt, first, exp_cyc);
      run_sweep(-1, cycles, stim_errs, e0, d0);
      n_checks++;
      if (cycles != exp_cyc || int'(err_cnt) != cnt || pass !== (cnt == 0) ||
          ffv !== (cnt > 0) || int'(ffvec) != ((first < 0) ? 0 : first) || stim_errs != 0) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: got cyc=%0d err=%0d pass=%b ffv=%b ffvec=%0d stimerr=%0d want cyc=%0d err=%0d first=%0d",
                 it, cycles, err_cnt, pass, ffv, ffvec, stim_errs, exp_cyc, cnt, first);
      end
    end
  endtask

  task automatic test_start_during_run();
    int cnt, first, exp_cyc, cycles, stim_errs, e0;
    logic d0;
    for (int v = 0; v < NVEC; v++) fault_mask[v] = (v == 6) ? 8'h40 : 8'h00;
    model_sweep(cnt, first, exp_cyc);
    run_sweep(4, cycles, stim_errs, e0, d0);
    n_checks++;
    if (cycles != exp_cyc || done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL start_during_run_latency: got %0d cycles done=%b want %0d cycles done=1", cycles, done, exp_cyc);
    end
    n_checks++;
    if (int'(err_cnt) != cnt || int'(ffvec) != first || stim_errs != 0) begin
      n_fail++;
      $display("[TB] FAIL start_during_run_result: got err=%0d ffvec=%0d stimerr=%0d want err=%0d ffvec=%0d stimerr=0",
               err_cnt, ffvec, stim_errs, cnt, first);
    end
  endtask

  task automatic test_restart_from_done();
    int cnt, first, exp_cyc, cycles, stim_errs, e0;
    logic d0;
    for (int v = 0; v < NVEC; v++) fault_mask[v] = 8'h81;
    run_sweep(-1, cycles, stim_errs, e0, d0);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_cnt === '0) begin
      n_fail++;
      $display("[TB] FAIL restart_setup: got done=%b pass=%b err=%0d want done=1 pass=0 err>0", done, pass, err_cnt);
    end
    for (int v = 0; v < NVEC; v++) fault_mask[v] = 8'h00;
    model_sweep(cnt, first, exp_cyc);
    run_sweep(-1, cycles, stim_errs, e0, d0);
    n_checks++;
    if (e0 != 0 || d0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_clear: got err=%0d done=%b after start want 0 and 0", e0, d0);
    end
    n_checks++;
    if (cycles != exp_cyc || pass !== 1'b1 || ffv !== 1'b0 || err_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL restart_rerun: got cyc=%0d pass=%b ffv=%b err=%0d want cyc=%0d pass=1 ffv=0 err=0",
               cycles, pass, ffv, err_cnt, exp_cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt, first, exp_cyc, cycles, stim_errs, e0, exp_mid;
    logic d0;
    for (int v = 0; v < NVEC; v++) fault_mask[v] = 8'hFF;
    exp_mid = STOP_ON_FAIL ? 1 : 7 / CPV;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (int'(err_cnt) != exp_mid) begin
      n_fail++;
      $display("[TB] FAIL mid_run_err: got %0d want %0d", err_cnt, exp_mid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, pass, err_cnt, ffv, ffvec, stim} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_mid_run: outputs got %b want all zero", {busy, done, pass, err_cnt, ffv, ffvec, stim});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < NVEC; v++) fault_mask[v] = 8'h00;
    model_sweep(cnt, first, exp_cyc);
    run_sweep(-1, cycles, stim_errs, e0, d0);
    n_checks++;
    if (cycles != exp_cyc || pass !== 1'b1 || err_cnt !== '0 || stim_errs != 0) begin
      n_fail++;
      $display("[TB] FAIL after_reset_sweep: got cyc=%0d pass=%b err=%0d stimerr=%0d want cyc=%0d pass=1 err=0 stimerr=0",
               cycles, pass, err_cnt, stim_errs, exp_cyc);
    end
  endtask

  task automatic test_small_config();
    int cycles;
    for (int f = 0; f < 2; f++) begin
      s_fault[0] = 1'b0;
      s_fault[1] = (f == 1);
      cycles = 0;
      @(negedge clk);
      s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      while (s_done !== 1'b1 && cycles < CYCLE_LIMIT) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      n_checks++;
      if (cycles != 2) begin
        n_fail++;
        $display("[TB] FAIL small_latency_%0d: got %0d cycles want 2", f, cycles);
      end
      n_checks++;
      if (s_pass !== (f == 0) || int'(s_err) != f || s_ffv !== (f == 1) || int'(s_ffvec) != f) begin
        n_fail++;
        $display("[TB] FAIL small_result_%0d: got pass=%b err=%0d ffv=%b ffvec=%0d want pass=%b err=%0d ffv=%b ffvec=%0d",
                 f, s_pass, s_err, s_ffv, s_ffvec, (f == 0), f, (f == 1), f);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    s_start    = 1'b0;
    s_fault[0] = 1'b0;
    s_fault[1] = 1'b0;
    for (int v = 0; v < NVEC; v++) fault_mask[v] = 8'h00;
    test_reset();
    test_fault_patterns();
    test_random_faults();
    test_start_during_run();
    test_restart_from_done();
    test_reset_mid_run();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vec_sweep_checker.md
Name: vec_sweep_checker

Overview:
- Parametrised, self-checking exhaustive-stimulus engine for combinational blocks: gate, half/full adder, 2x1/4x1 mux, 3-to-8 decoder and wider successors.
- Steps a counter through every input vector 0 .. 2^IN_W-1 and drives it into the DUT.
- Waits a programmable settle time per vector, then compares DUT output against a reference-model output.
- Reports mismatch count, first failing vector and pass/done status. Sits between the testbench and the DUT/model pair and replaces hand-written stimulus lists.

Parameters:
- IN_W, 3, DUT input vector width (1..16).
- OUT_W, 8, DUT output width compared per vector (1..64).
- SETTLE, 1, idle cycles per vector between applying the vector and sampling outputs (0..255).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  begin sweep; sampled only in IDLE or DONE.
- i_dut_y  input  OUT_W  DUT output.
- i_exp_y  input  OUT_W  reference-model output for the same o_stim.
- o_stim  output  IN_W  vector driven to DUT and model.
- o_busy  output  1  sweep in progress.
- o_done  output  1  sweep finished; level, held until the next start.
- o_pass  output  1  valid when o_done=1; high iff o_err_cnt==0.
- o_err_cnt  output  IN_W+1  mismatching vector count, saturating at 2^IN_W.
- o_first_fail_valid  output  1  at least one mismatch recorded.
- o_first_fail_vec  output  IN_W  lowest-numbered failing vector.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal vector counter and settle counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + i_start=1 at edge k → RUN at edge k:
  - o_stim=0, settle_cnt=0, o_busy=1, o_done=0, o_pass=0.
  - o_err_cnt and first-fail regs cleared.
- RUN, settle_cnt<SETTLE: settle_cnt++, o_stim held.
- RUN, settle_cnt==SETTLE (compare edge):
  - Sample i_dut_y != i_exp_y (full OUT_W bits, X/Z compare as mismatch in sim).
  - On mismatch: o_err_cnt++. If o_first_fail_valid=0, latch o_first_fail_vec=o_stim and set o_first_fail_valid=1.
  - If o_stim != 2^IN_W-1: o_stim++, settle_cnt=0.
  - Else: go to DONE.
- DONE entry, same edge as the last compare:
  - o_busy=0, o_done=1, o_stim=0.
  - o_pass = (updated err count == 0).
- Latency: o_done rises at edge k + 2^IN_W*(SETTLE+1). Default parameters give 16 cycles.
- SETTLE=0: compare on the edge immediately after the vector is applied; one vector per cycle.
- i_start while RUN: ignored, with no restart or clear.
- i_start in DONE: restarts exactly as from IDLE.
- o_err_cnt width IN_W+1 holds the all-fail value 2^IN_W exactly; saturate as a guard.
- Reset mid-RUN: immediate return to IDLE; all results lost; no partial done.
- DUT and model must be combinational, or have latency ≤ SETTLE cycles.

Optional Feature:
- Macro SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep on that compare edge and goes to DONE. o_err_cnt=1, o_pass=0, o_first_fail_vec holds the failing vector, and the remaining vectors are not applied.
- Undefined: the full sweep always runs; all mismatches are counted.

Decomposition:
- Package sweep_pkg holds:
  - sweep_state_t enum (IDLE, RUN, DONE);
  - localparam SETTLE_W = $clog2(SETTLE+1), minimum 1.
- One natural sub-module, sweep_vec_ctr: vector counter plus settle counter. Outputs o_stim, a compare strobe and a last-vector flag.
- FSM and result registers stay in the top module.

Test Plan:
- All default parameters:
  - i_exp_y tied to i_dut_y (decoder + golden model), pulse i_start → o_done high 16 cycles later, o_pass=1, o_err_cnt=0, o_first_fail_valid=0, o_stim stepped 0..7.
  - DUT output bit 0 forced wrong only when o_stim==5 → o_err_cnt=1, o_first_fail_vec=5, o_pass=0.
  - i_dut_y=~i_exp_y for all vectors → o_err_cnt=8 (4'b1000), o_first_fail_vec=0.
  - Assert i_rst at cycle 7 of a sweep → all outputs 0 immediately. A new i_start then gives a clean 16-cycle pass.
  - i_start re-pulsed at cycle 4 of a sweep → ignored; o_done still at cycle 16. i_start in DONE → results cleared, sweep repeats.
- IN_W=1, OUT_W=1, SETTLE=0, AND-gate DUT vs model → o_done after 2 cycles, pass.
- With SWEEP_STOP_ON_FAIL_EN and a mismatch at vectors 2 and 6 → DONE after vector 2's compare (cycle 6), o_err_cnt=1, o_first_fail_vec=2.
